// File: rtl/acq_event_sequencer.sv
// Acquisition sequencer: counts qualified START/STOP events from N sources,
// optionally waits for gate pulses, enforces a tick-based timeout and reports
// why each run ended. All outputs are registered from next-state values, so
// they line up with the state register.
module acq_event_sequencer #(
  parameter int NUM_EVT_SRC   = 4,
  parameter int CNT_WIDTH     = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     CLK40MHZ,
  input  logic                     RESET_N,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic [NUM_EVT_SRC-1:0]   EVT_IN,
  input  logic [NUM_EVT_SRC-1:0]   START_MASK,
  input  logic [NUM_EVT_SRC-1:0]   STOP_MASK,
  input  logic [CNT_WIDTH-1:0]     START_NUM,
  input  logic [CNT_WIDTH-1:0]     STOP_NUM,
  input  logic                     START_GATE_EN,
  input  logic                     START_GATE,
  input  logic                     STOP_GATE_EN,
  input  logic                     STOP_GATE,
  input  logic                     TICK,
  input  logic [TIMEOUT_WIDTH-1:0] TIMEOUT,
  input  logic                     MEM_FULL,
  output logic                     WAITING,
  output logic                     ACQUIRING,
  output logic                     DONE,
  output logic [1:0]               END_CAUSE,
  output logic [CNT_WIDTH-1:0]     EVT_REMAIN
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GATE  = 3'd1,
    S_WAIT  = 3'd2,
    S_SGATE = 3'd3,
    S_ACQ   = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_COUNT   = 2'b00;
  localparam logic [1:0] CAUSE_MEMFULL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_ABORT   = 2'b11;

  localparam logic [CNT_WIDTH-1:0]     CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ZERO = {TIMEOUT_WIDTH{1'b0}};
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_MAX  = {TIMEOUT_WIDTH{1'b1}};
  localparam logic [NUM_EVT_SRC-1:0]   EVT_ZERO = {NUM_EVT_SRC{1'b0}};
  localparam logic [NUM_EVT_SRC-1:0]   EVT_ONES = {NUM_EVT_SRC{1'b1}};

  state_t                   state_r, state_nxt_s;
  logic [NUM_EVT_SRC-1:0]   evt_q_r, evt_qq_r, evt_rise_s;
  logic                     sev_s, pev_s;
  logic [CNT_WIDTH-1:0]     scnt_r, scnt_nxt_s;
  logic [CNT_WIDTH-1:0]     ecnt_r, ecnt_nxt_s;
  logic [TIMEOUT_WIDTH-1:0] tcnt_r, tcnt_nxt_s, tcnt_inc_s;
  logic                     timeout_hit_s;
  state_t                   adv_state_s;
  logic                     done_s;
  logic [1:0]               cause_s;
  logic                     waiting_s, acquiring_s;
  logic [CNT_WIDTH-1:0]     remain_s;
  logic                     waiting_r, acquiring_r, done_r;
  logic [1:0]               end_cause_r;
  logic [CNT_WIDTH-1:0]     remain_r;

  // Two-stage edge pipeline; all-ones reset suppresses edges from sources high at release
  always_ff @(posedge CLK40MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      evt_q_r  <= EVT_ONES;
      evt_qq_r <= EVT_ONES;
    end else begin
      evt_q_r  <= EVT_IN;
      evt_qq_r <= evt_q_r;
    end
  end

  // Rising edges merged per side: coincident edges form a single event
  always_comb begin
    evt_rise_s = evt_q_r & ~evt_qq_r;
    sev_s      = |(evt_rise_s & START_MASK);
    pev_s      = |(evt_rise_s & STOP_MASK);
  end

  // Saturating tick count and timeout detection on the post-tick value
  always_comb begin
    if (TICK && (tcnt_r != TMO_MAX)) begin
      tcnt_inc_s = tcnt_r + TMO_ONE;
    end else begin
      tcnt_inc_s = tcnt_r;
    end
    timeout_hit_s = (TIMEOUT != TMO_ZERO) && (tcnt_inc_s >= TIMEOUT);
    adv_state_s   = STOP_GATE_EN ? S_SGATE : S_ACQ;
  end

  // State and counter registers
  always_ff @(posedge CLK40MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= S_IDLE;
      scnt_r  <= CNT_ZERO;
      ecnt_r  <= CNT_ZERO;
      tcnt_r  <= TMO_ZERO;
    end else begin
      state_r <= state_nxt_s;
      scnt_r  <= scnt_nxt_s;
      ecnt_r  <= ecnt_nxt_s;
      tcnt_r  <= tcnt_nxt_s;
    end
  end

  // Next-state and counter update: ABORT > MEM_FULL > timeout > events
  always_comb begin
    state_nxt_s = state_r;
    scnt_nxt_s  = scnt_r;
    ecnt_nxt_s  = ecnt_r;
    tcnt_nxt_s  = tcnt_r;
    done_s      = 1'b0;
    cause_s     = end_cause_r;
    case (state_r)
      S_IDLE: begin
        if (START && !ABORT) begin
          scnt_nxt_s  = START_NUM;
          ecnt_nxt_s  = STOP_NUM;
          tcnt_nxt_s  = TMO_ZERO;
          state_nxt_s = START_GATE_EN ? S_GATE : S_WAIT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_GATE, S_WAIT: begin
        tcnt_nxt_s = tcnt_inc_s;
        if (ABORT) begin
          state_nxt_s = S_IDLE;
          done_s      = 1'b1;
          cause_s     = CAUSE_ABORT;
        end else if (timeout_hit_s) begin
          state_nxt_s = S_IDLE;
          done_s      = 1'b1;
          cause_s     = CAUSE_TIMEOUT;
        end else if (state_r == S_GATE) begin
          state_nxt_s = START_GATE ? S_WAIT : S_GATE;
        end else if (START_MASK == EVT_ZERO) begin
          state_nxt_s = adv_state_s;
        end else if (sev_s) begin
          if (scnt_r != CNT_ZERO) begin
            scnt_nxt_s = scnt_r - CNT_ONE;
          end else begin
            state_nxt_s = adv_state_s;
          end
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_SGATE, S_ACQ: begin
        if (ABORT) begin
          state_nxt_s = S_IDLE;
          done_s      = 1'b1;
          cause_s     = CAUSE_ABORT;
        end else if (MEM_FULL) begin
          state_nxt_s = S_IDLE;
          done_s      = 1'b1;
          cause_s     = CAUSE_MEMFULL;
        end else if (state_r == S_SGATE) begin
          state_nxt_s = STOP_GATE ? S_ACQ : S_SGATE;
        end else if ((STOP_MASK == EVT_ZERO) || (pev_s && (ecnt_r == CNT_ZERO))) begin
          state_nxt_s = S_IDLE;
          done_s      = 1'b1;
          cause_s     = CAUSE_COUNT;
        end else if (pev_s) begin
          ecnt_nxt_s = ecnt_r - CNT_ONE;
        end else begin
          state_nxt_s = S_ACQ;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs track it
  always_comb begin
    waiting_s   = 1'b0;
    acquiring_s = 1'b0;
    remain_s    = scnt_nxt_s;
    case (state_nxt_s)
      S_GATE, S_WAIT: begin
        waiting_s = 1'b1;
      end
      S_SGATE, S_ACQ: begin
        acquiring_s = 1'b1;
        remain_s    = ecnt_nxt_s;
      end
      default: begin
        remain_s = scnt_nxt_s;
      end
    endcase
  end

  // Output registers; END_CAUSE only changes when a run ends
  always_ff @(posedge CLK40MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      waiting_r   <= 1'b0;
      acquiring_r <= 1'b0;
      done_r      <= 1'b0;
      end_cause_r <= CAUSE_COUNT;
      remain_r    <= CNT_ZERO;
    end else begin
      waiting_r   <= waiting_s;
      acquiring_r <= acquiring_s;
      done_r      <= done_s;
      end_cause_r <= cause_s;
      remain_r    <= remain_s;
    end
  end

  assign WAITING    = waiting_r;
  assign ACQUIRING  = acquiring_r;
  assign DONE       = done_r;
  assign END_CAUSE  = end_cause_r;
  assign EVT_REMAIN = remain_r;

endmodule
